prism_sit_load_ctrl: RTL and testbench
======================================

Name: prism_sit_load_ctrl

Overview:
Sequencer that loads a complete PRISM State Information Table from a 32-bit valid/ready word stream, such as a host FIFO or a config DMA.
- Packs words into WIDTH-bit rows.
- Drives the latch shift-register chain with latch-safe timing: data stable, then strobe, then hold.
- Raises a halt request so the PRISM engine does not read the SIT while the load is in progress.
- Sits between the host/peripheral bus and the SIT latch chain.

Parameters:
WIDTH, 80, bits per SIT row (33..64*WPR; rows wider than 32 bits).
DEPTH, 2, number of SIT rows (1..64).
WPR, (WIDTH+31)/32, derived; 32-bit words per row.
C_BITS, clog2(DEPTH+1), derived; width of rows_loaded.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin full-table load; sampled only in IDLE
abort  in  1  cancel load; has priority over start
in_valid  in  1  stream word valid
in_data  in  32  stream word
in_ready  out  1  controller accepts word when in_valid&in_ready
cfg_data  out  WIDTH  row data to latch chain
cfg_shift  out  1  one-cycle latch-chain shift strobe (registered)
busy  out  1  high in every state except IDLE
halt_req  out  1  equals busy; engine must freeze SIT reads
done  out  1  one-cycle pulse on successful completion
rows_loaded  out  C_BITS  rows strobed since last start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including cfg_data, rows_loaded, word_idx and row_cnt.
  - Reset mid-load: no further strobes; the partial table is left as-is.
- States: IDLE, COLLECT, SETUP, STROBE, HOLD, DONE. All outputs are registered or decoded from registered state only; in_ready is 1 exactly in COLLECT.
- IDLE:
  - start=1 and abort=0 -> COLLECT; clear word_idx, row_cnt and rows_loaded.
- COLLECT:
  - On each accepted word: cfg_data[32*word_idx +: 32] <= in_data. Bits beyond WIDTH-1 in the last word are discarded.
  - word_idx increments per accepted word; in_valid=0 stalls indefinitely.
  - Acceptance of word WPR-1 -> SETUP, and word_idx <= 0.
- SETUP: 1 cycle; cfg_data is stable and cfg_shift=0. -> STROBE.
- STROBE: 1 cycle; cfg_shift=1; rows_loaded increments. -> HOLD.
- HOLD: 1 cycle; cfg_data is unchanged and cfg_shift=0.
  - row_cnt==DEPTH-1 -> DONE.
  - Otherwise row_cnt++ and -> COLLECT.
- DONE: 1 cycle with done=1. -> IDLE.
- cfg_data changes only on accepted words in COLLECT. This guarantees at least one stable cycle before and after every cfg_shift.
- Row order: the first row received is the first shifted. After DEPTH strobes it occupies the deepest chain position (row DEPTH-1).
- Latency with in_valid held high: (WPR+3)*DEPTH cycles from the start edge to the DONE state. For the defaults, done is high in the 13th cycle after start is sampled.
- Boundary conditions:
  - start while busy: ignored, no effect on the load.
  - abort in any non-IDLE state: next edge -> IDLE.
    - done is not pulsed; in_ready and busy drop at that edge.
    - A cfg_shift already high in the abort cycle completes; no new strobe is issued.
    - rows_loaded holds its value for diagnosis.
  - abort and start together in IDLE: stay in IDLE.
  - in_valid with in_ready=0: word not consumed; the source must hold it.
  - DEPTH=1: after HOLD, go directly to DONE.

Decomposition:
- Package prism_sit_pkg holds:
  - state encoding constants (ST_IDLE..ST_DONE);
  - the clog2 function;
  - the WPR derivation, shared with the latch loader and SIT.
- One sub-module, prism_sit_row_packer: word_idx counter plus the WIDTH-bit row register with slot write-enable and truncation of the final word.
- The FSM, row counter and output flops stay in the top module.

Test Plan:
1. Defaults; start with stream words 0x11111111, 0x22222222, 0x000000AB, then 0x33333333, 0x44444444, 0x000000CD, in_valid held high -> two cfg_shift pulses with cfg_data=0xAB_22222222_11111111 then 0xCD_44444444_33333333; done in cycle 13; rows_loaded=2; busy low afterwards.
2. Same stream with in_valid deasserted 5 cycles between every word -> identical cfg_data/cfg_shift sequence; cfg_shift count=2; cfg_data constant during every SETUP/STROBE/HOLD.
3. Abort asserted in the cycle after the first cfg_shift -> IDLE next edge; no second strobe; done never pulses; rows_loaded=1; in_ready=0.
4. start pulsed while in COLLECT, and start+abort together in IDLE -> the first has no effect on the count or sequence; the second leaves state in IDLE with busy=0.
5. rst_n driven low during the STROBE cycle of row 0 -> all outputs 0 immediately (async); after release, state is IDLE and no cfg_shift occurs until a new start.
6. WIDTH=40, DEPTH=1; words 0xDEADBEEF, 0xFFFFFF5A -> single strobe with cfg_data=0x5A_DEADBEEF (upper 24 bits discarded); done 6 cycles after start.

Source files
------------

// File: rtl/prism_sit_pkg.sv
// Shared definitions for the PRISM SIT load path: FSM encodings and the
// row/word geometry helpers used by the loader, the latch chain and the SIT.
package prism_sit_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_STROBE  = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned words_per_row(input int unsigned width);
        return (width + 32'd31) / 32'd32;
    endfunction

endpackage

// File: rtl/prism_sit_row_packer.sv
// Packs accepted 32-bit stream words into one WIDTH-bit SIT row; the final
// word is truncated to the bits the row actually has.
module prism_sit_row_packer
    import prism_sit_pkg::*;
#(
    parameter  int unsigned WIDTH = 80,
    localparam int unsigned WPR   = words_per_row(WIDTH),
    localparam int unsigned IDX_W = clog2(WPR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_accept,
    input  logic [31:0]      i_data,
    output logic             o_last,
    output logic [WIDTH-1:0] o_row
);

    logic [IDX_W-1:0] r_word_idx;

    assign o_last = (r_word_idx == IDX_W'(WPR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx <= '0;
        end else if (i_clr) begin
            r_word_idx <= '0;
        end else if (i_accept) begin
            r_word_idx <= o_last ? '0 : r_word_idx + 1'b1;
        end
    end

    // One register per word slot so each slot has a single owner; the last
    // slot is only as wide as the remaining row bits.
    for (genvar w = 0; w < WPR; w++) begin : g_slot
        localparam int unsigned LO     = 32 * w;
        localparam int unsigned SLOT_W = ((WIDTH - LO) > 32) ? 32 : (WIDTH - LO);

        logic              w_we;
        logic [SLOT_W-1:0] r_slot;

        assign w_we = i_accept && (r_word_idx == IDX_W'(w));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot <= '0;
            end else if (w_we) begin
                r_slot <= i_data[SLOT_W-1:0];
            end
        end

        assign o_row[LO +: SLOT_W] = r_slot;
    end

endmodule

// File: rtl/prism_sit_load_ctrl.sv
// Loads a full PRISM SIT from a 32-bit valid/ready stream, driving the latch
// chain with setup/strobe/hold sequencing and holding the engine off meanwhile.
module prism_sit_load_ctrl
    import prism_sit_pkg::*;
#(
    parameter  int unsigned WIDTH  = 80,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned WPR    = words_per_row(WIDTH),
    localparam int unsigned C_BITS = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic [WIDTH-1:0]  cfg_data,
    output logic              cfg_shift,
    output logic              busy,
    output logic              halt_req,
    output logic              done,
    output logic [C_BITS-1:0] rows_loaded
);

    logic [2:0]        r_state;
    logic [C_BITS-1:0] r_row_cnt;
    logic [C_BITS-1:0] r_rows_loaded;
    logic              r_cfg_shift;
    logic              r_done;

    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_word;
    logic              w_last_row;
    logic              w_abort_load;

    assign w_accept     = in_valid && in_ready;
    assign w_start_ok   = (r_state == ST_IDLE) && start && !abort;
    assign w_last_row   = (r_row_cnt == C_BITS'(DEPTH - 1));
    assign w_abort_load = abort && (r_state != ST_IDLE);

    prism_sit_row_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_start_ok),
        .i_accept (w_accept),
        .i_data   (in_data),
        .o_last   (w_last_word),
        .o_row    (cfg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (w_abort_load) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_start_ok) r_state <= ST_COLLECT;
                ST_COLLECT: if (w_accept && w_last_word) r_state <= ST_SETUP;
                ST_SETUP:   r_state <= ST_STROBE;
                ST_STROBE:  r_state <= ST_HOLD;
                ST_HOLD:    r_state <= w_last_row ? ST_DONE : ST_COLLECT;
                ST_DONE:    r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt <= '0;
        end else if (w_start_ok) begin
            r_row_cnt <= '0;
        end else if (!abort && (r_state == ST_HOLD) && !w_last_row) begin
            r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    // A strobe already on the wire counts even if abort arrives with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows_loaded <= '0;
        end else if (w_start_ok) begin
            r_rows_loaded <= '0;
        end else if (r_state == ST_STROBE) begin
            r_rows_loaded <= r_rows_loaded + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_shift <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cfg_shift <= (r_state == ST_SETUP) && !abort;
            r_done      <= (r_state == ST_HOLD) && w_last_row && !abort;
        end
    end

    assign in_ready    = (r_state == ST_COLLECT);
    assign busy        = (r_state != ST_IDLE);
    assign halt_req    = busy;
    assign cfg_shift   = r_cfg_shift;
    assign done        = r_done;
    assign rows_loaded = r_rows_loaded;

endmodule

// File: tb/tb_prism_sit_load_ctrl.sv
// Self-checking bench for prism_sit_load_ctrl: a default 80x2 instance and a
// 40x1 instance, with expected rows built from the word stream arithmetically.
module tb_prism_sit_load_ctrl;

    localparam int unsigned AW = 80;
    localparam int unsigned AD = 2;
    localparam int unsigned BW = 40;
    localparam int unsigned BD = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] words[12];

    // ---------------- instance A (80 x 2) ----------------
    logic          a_rst_n = 1'b0, a_start = 1'b0, a_abort = 1'b0, a_in_valid = 1'b0;
    logic [31:0]   a_in_data = '0;
    logic          a_in_ready, a_cfg_shift, a_busy, a_halt, a_done;
    logic [AW-1:0] a_cfg;
    logic [1:0]    a_rows;

    prism_sit_load_ctrl #(.WIDTH(AW), .DEPTH(AD)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .abort(a_abort),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .cfg_data(a_cfg), .cfg_shift(a_cfg_shift), .busy(a_busy),
        .halt_req(a_halt), .done(a_done), .rows_loaded(a_rows)
    );

    // ---------------- instance B (40 x 1) ----------------
    logic          b_rst_n = 1'b0, b_start = 1'b0, b_abort = 1'b0, b_in_valid = 1'b0;
    logic [31:0]   b_in_data = '0;
    logic          b_in_ready, b_cfg_shift, b_busy, b_halt, b_done;
    logic [BW-1:0] b_cfg;
    logic [0:0]    b_rows;

    prism_sit_load_ctrl #(.WIDTH(BW), .DEPTH(BD)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .abort(b_abort),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .cfg_data(b_cfg), .cfg_shift(b_cfg_shift), .busy(b_busy),
        .halt_req(b_halt), .done(b_done), .rows_loaded(b_rows)
    );

    // ---------------- monitors ----------------
    logic [AW-1:0] a_shift_q[$];
    int unsigned   a_done_cnt = 0, a_unstable = 0, a_halt_err = 0;
    time           a_done_t = 0, a_t0 = 0;
    logic [AW-1:0] a_prev_cfg = '0, a_last_shift = '0;
    bit            a_chk_next = 1'b0;

    always @(negedge clk) begin
        if (a_halt !== a_busy) a_halt_err++;
        if (a_cfg_shift === 1'b1) begin
            a_shift_q.push_back(a_cfg);
            if (a_cfg !== a_prev_cfg) a_unstable++;
            a_last_shift = a_cfg;
            a_chk_next   = 1'b1;
        end else if (a_chk_next) begin
            if (a_cfg !== a_last_shift) a_unstable++;
            a_chk_next = 1'b0;
        end
        if (a_done === 1'b1) begin
            a_done_cnt++;
            a_done_t = $time;
        end
        a_prev_cfg = a_cfg;
    end

    logic [BW-1:0] b_shift_q[$];
    int unsigned   b_done_cnt = 0;
    time           b_done_t = 0, b_t0 = 0;

    always @(negedge clk) begin
        if (b_cfg_shift === 1'b1) b_shift_q.push_back(b_cfg);
        if (b_done === 1'b1) begin
            b_done_cnt++;
            b_done_t = $time;
        end
    end

    // Row r is words[r*wpr .. r*wpr+wpr-1], little-endian, cut to width bits.
    function automatic logic [127:0] model_row(input int unsigned width, input int unsigned r);
        int unsigned  wpr;
        logic [127:0] acc;
        wpr = (width + 31) / 32;
        acc = '0;
        for (int unsigned k = 0; k < wpr; k++)
            acc = acc | ({96'b0, words[r*wpr + k]} << (32 * k));
        acc = acc & ((128'd1 << width) - 128'd1);
        return acc;
    endfunction

    // ---------------- drivers ----------------
    task automatic a_clear_mon();
        @(posedge clk);
        #1;
        a_shift_q.delete();
        a_done_cnt = 0; a_unstable = 0; a_halt_err = 0; a_chk_next = 1'b0;
        a_done_t   = 0;
    endtask

    task automatic a_begin();
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        a_t0 = $time;
        #1 a_start = 1'b0;
    endtask

    task automatic a_send(input logic [31:0] w, input int unsigned gap, output bit to);
        int unsigned n;
        to = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = w;
        n = 0;
        while (a_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            to = 1'b1;
            a_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = $urandom;
    endtask

    task automatic a_wait_idle(output bit to);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (a_busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 200);
    endtask

    task automatic a_wait_shift(output bit to);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (a_cfg_shift !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 50);
    endtask

    // Full-table load on A; start_at < 6 re-pulses start before that word.
    task automatic a_run(input int unsigned gap, input bit rand_gap, input int unsigned start_at,
                         output bit to);
        bit t;
        to = 1'b0;
        a_begin();
        for (int unsigned i = 0; i < 6; i++) begin
            if (i == start_at) begin
                @(negedge clk);
                a_start = 1'b1;
                @(posedge clk);
                #1 a_start = 1'b0;
            end
            a_send(words[i], rand_gap ? $urandom_range(0, 3) : gap, t);
            if (t) begin
                to = 1'b1;
                return;
            end
        end
        a_wait_idle(t);
        to = t;
    endtask

    task automatic a_check_table(input string tag);
        logic [127:0] e;
        total++;
        if (a_shift_q.size() != 2) begin
            bad++;
            $display("FAIL %s shift_count: got %0d want 2", tag, a_shift_q.size());
        end
        for (int unsigned r = 0; r < 2; r++) begin
            e = model_row(AW, r);
            total++;
            if (a_shift_q.size() <= r || a_shift_q[r] !== e[AW-1:0]) begin
                bad++;
                $display("FAIL %s row%0d cfg_data: got %h want %h", tag, r,
                         (a_shift_q.size() > r) ? a_shift_q[r] : '0, e[AW-1:0]);
            end
        end
        total++;
        if (a_done_cnt != 1 || a_rows !== 2'd2 || a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s completion: done_cnt=%0d rows=%0d busy=%b in_ready=%b want 1,2,0,0",
                     tag, a_done_cnt, a_rows, a_busy, a_in_ready);
        end
        total++;
        if (a_unstable != 0 || a_halt_err != 0) begin
            bad++;
            $display("FAIL %s stability: unstable=%0d halt_err=%0d want 0,0", tag, a_unstable, a_halt_err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        total++;
        if (a_in_ready !== 0 || a_cfg !== '0 || a_cfg_shift !== 0 || a_busy !== 0 ||
            a_halt !== 0 || a_done !== 0 || a_rows !== '0) begin
            bad++;
            $display("FAIL reset_a: ready=%b cfg=%h shift=%b busy=%b halt=%b done=%b rows=%0d want all 0",
                     a_in_ready, a_cfg, a_cfg_shift, a_busy, a_halt, a_done, a_rows);
        end
        total++;
        if (b_in_ready !== 0 || b_cfg !== '0 || b_cfg_shift !== 0 || b_busy !== 0 ||
            b_halt !== 0 || b_done !== 0 || b_rows !== '0) begin
            bad++;
            $display("FAIL reset_b: ready=%b cfg=%h shift=%b busy=%b halt=%b done=%b rows=%0d want all 0",
                     b_in_ready, b_cfg, b_cfg_shift, b_busy, b_halt, b_done, b_rows);
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
    endtask

    task automatic test_full_load();
        bit to;
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h000000AB;
        words[3] = 32'h33333333; words[4] = 32'h44444444; words[5] = 32'h000000CD;
        a_clear_mon();
        a_run(0, 1'b0, 99, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL full_timeout: got timeout want none");
        end
        a_check_table("full");
        total++;
        if (int'((a_done_t - a_t0 - 5) / 10) != 12) begin
            bad++;
            $display("FAIL full_latency: done after %0d edges want 12", int'((a_done_t - a_t0 - 5) / 10));
        end
    endtask

    task automatic test_stalled();
        bit to;
        a_clear_mon();
        a_run(5, 1'b0, 99, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL stalled_timeout: got timeout want none");
        end
        a_check_table("stalled");
    endtask

    task automatic test_random();
        bit to;
        for (int unsigned it = 0; it < 4; it++) begin
            for (int unsigned i = 0; i < 6; i++) words[i] = $urandom;
            a_clear_mon();
            a_run(0, 1'b1, 99, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL random%0d_timeout: got timeout want none", it);
            end
            a_check_table("random");
        end
    endtask

    task automatic test_abort();
        bit to;
        bit t;
        int unsigned ready_seen;
        for (int unsigned i = 0; i < 6; i++) words[i] = $urandom;
        a_clear_mon();
        a_begin();
        to = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            a_send(words[i], 0, t);
            to = to | t;
        end
        a_wait_shift(t);
        to = to | t;
        @(posedge clk);
        #1 a_abort = 1'b1;
        @(posedge clk);
        #1 a_abort = 1'b0;
        @(negedge clk);
        total++;
        if (to || a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_rows !== 2'd1) begin
            bad++;
            $display("FAIL abort_state: to=%b busy=%b in_ready=%b rows=%0d want 0,0,0,1",
                     to, a_busy, a_in_ready, a_rows);
        end
        a_in_valid = 1'b1;
        a_in_data  = words[3];
        ready_seen = 0;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_in_ready !== 1'b0) ready_seen++;
        end
        a_in_valid = 1'b0;
        total++;
        if (ready_seen != 0 || a_shift_q.size() != 1 || a_done_cnt != 0 || a_rows !== 2'd1) begin
            bad++;
            $display("FAIL abort_after: ready_seen=%0d shifts=%0d done_cnt=%0d rows=%0d want 0,1,0,1",
                     ready_seen, a_shift_q.size(), a_done_cnt, a_rows);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        int unsigned shifts;
        for (int unsigned i = 0; i < 6; i++) words[i] = $urandom;
        a_clear_mon();
        a_run(1, 1'b0, 1, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL start_busy_timeout: got timeout want none");
        end
        a_check_table("start_busy");
        shifts = a_shift_q.size();
        @(negedge clk);
        a_start = 1'b1;
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_abort = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_shift_q.size() != shifts) begin
            bad++;
            $display("FAIL start_abort_idle: busy=%b in_ready=%b shifts=%0d want 0,0,%0d",
                     a_busy, a_in_ready, a_shift_q.size(), shifts);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit t;
        for (int unsigned i = 0; i < 6; i++) words[i] = $urandom | 32'h1;
        a_clear_mon();
        a_begin();
        to = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            a_send(words[i], 0, t);
            to = to | t;
        end
        a_wait_shift(t);
        to = to | t;
        #1 a_rst_n = 1'b0;
        #1;
        total++;
        if (to || a_in_ready !== 0 || a_cfg !== '0 || a_cfg_shift !== 0 || a_busy !== 0 ||
            a_halt !== 0 || a_done !== 0 || a_rows !== '0) begin
            bad++;
            $display("FAIL reset_mid: to=%b ready=%b cfg=%h shift=%b busy=%b halt=%b done=%b rows=%0d want all 0",
                     to, a_in_ready, a_cfg, a_cfg_shift, a_busy, a_halt, a_done, a_rows);
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (a_shift_q.size() != 1 || a_busy !== 1'b0 || a_done_cnt != 0) begin
            bad++;
            $display("FAIL reset_after: shifts=%0d busy=%b done_cnt=%0d want 1,0,0",
                     a_shift_q.size(), a_busy, a_done_cnt);
        end
        a_clear_mon();
        a_run(0, 1'b0, 99, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL reset_reload_timeout: got timeout want none");
        end
        a_check_table("reset_reload");
    endtask

    task automatic test_narrow();
        logic [127:0] e;
        int unsigned  n;
        for (int unsigned it = 0; it < 3; it++) begin
            if (it == 0) begin
                words[0] = 32'hDEADBEEF;
                words[1] = 32'hFFFFFF5A;
            end else begin
                words[0] = $urandom;
                words[1] = $urandom;
            end
            e = model_row(BW, 0);
            @(posedge clk);
            #1;
            b_shift_q.delete();
            b_done_cnt = 0;
            @(negedge clk);
            b_start = 1'b1;
            @(posedge clk);
            b_t0 = $time;
            #1 b_start = 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                @(negedge clk);
                b_in_valid = 1'b1;
                b_in_data  = words[i];
                n = 0;
                while (b_in_ready !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1 b_in_valid = 1'b0;
            end
            n = 0;
            @(negedge clk);
            while (b_busy !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (b_shift_q.size() != 1 || b_shift_q[0] !== e[BW-1:0]) begin
                bad++;
                $display("FAIL narrow%0d_row: shifts=%0d cfg=%h want 1,%h", it, b_shift_q.size(),
                         (b_shift_q.size() > 0) ? b_shift_q[0] : '0, e[BW-1:0]);
            end
            total++;
            if (n >= 100 || b_done_cnt != 1 || b_rows !== 1'b1 ||
                int'((b_done_t - b_t0 - 5) / 10) != 5) begin
                bad++;
                $display("FAIL narrow%0d_done: idle_wait=%0d done_cnt=%0d rows=%0d edges=%0d want <100,1,1,5",
                         it, n, b_done_cnt, b_rows, int'((b_done_t - b_t0 - 5) / 10));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stalled();
        test_random();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
